// File: rtl/ov7670_config_ctrl_if.sv
// +----------------------------------------------------------------------------+
// | Module   : ov7670_config_ctrl_if                                           |
// | Purpose  : Table-ROM / SCCB-sender / status bundle for ov7670_config_ctrl. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

interface ov7670_config_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_data;
  logic              send;
  logic              taken;
  logic [7:0]        id;
  logic [7:0]        regi;
  logic [7:0]        value;
  logic              resend;
  logic              busy;
  logic              done;

  modport master (
    output rom_addr, send, id, regi, value, busy, done,
    input  rom_data, taken, resend
  );

  modport slave (
    input  rom_addr, send, id, regi, value, busy, done,
    output rom_data, taken, resend
  );
endinterface

`default_nettype wire

// File: rtl/ov7670_config_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module   : ov7670_config_ctrl                                              |
// | Purpose  : Walks the OV7670 register table and issues one SCCB write at a  |
// |            time to the byte sender; supports delay entries and re-runs.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module ov7670_config_ctrl #(
  parameter logic [7:0] CAM_ID      = 8'h42,
  parameter int         ADDR_W      = 8,
  parameter int         STARTUP_CYC = 1_000_000,
  parameter int         GAP_CYC     = 10_000,
  parameter int         DELAY_CYC   = 1_000_000
) (
  input  wire logic             clk,
  input  wire logic             rst,
  ov7670_config_ctrl_if.master  bus
);

  localparam logic [15:0] c_END_MARK   = 16'hFFFF;
  localparam logic [15:0] c_DELAY_MARK = 16'hFFF0;
  localparam int c_MAX_SD  = (STARTUP_CYC > DELAY_CYC) ? STARTUP_CYC : DELAY_CYC;
  localparam int c_MAX_CYC = (c_MAX_SD > GAP_CYC) ? c_MAX_SD : GAP_CYC;
  localparam int c_CNT_W   = $clog2(c_MAX_CYC + 1);

  typedef enum logic [2:0] {
    S_STARTUP = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_SEND    = 3'd3,
    S_GAP     = 3'd4,
    S_DELAY   = 3'd5,
    S_ADVANCE = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_addr,  w_addr_nxt;
  logic [c_CNT_W-1:0]  r_cnt,   w_cnt_nxt;
  logic                r_send,  w_send_nxt;
  logic [7:0]          r_regi,  w_regi_nxt;
  logic [7:0]          r_value, w_value_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_STARTUP;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_send  <= 1'b0;
      r_regi  <= 8'h00;
      r_value <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_send  <= w_send_nxt;
      r_regi  <= w_regi_nxt;
      r_value <= w_value_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_send_nxt  = r_send;
    w_regi_nxt  = r_regi;
    w_value_nxt = r_value;
    w_cnt_nxt   = r_cnt;

    case (r_state)
      S_STARTUP: if (r_cnt == c_CNT_W'(STARTUP_CYC - 1)) w_state_nxt = S_FETCH;
      S_FETCH:   w_state_nxt = S_DECODE;
      S_DECODE: begin
        if (bus.rom_data == c_END_MARK) begin
          w_state_nxt = S_DONE;
        end else if (bus.rom_data == c_DELAY_MARK) begin
          w_state_nxt = S_DELAY;
        end else begin
          w_regi_nxt  = bus.rom_data[15:8];
          w_value_nxt = bus.rom_data[7:0];
          w_send_nxt  = 1'b1;
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        if (bus.taken) begin
          w_send_nxt  = 1'b0;
          w_state_nxt = S_GAP;
        end
      end
      S_GAP:     if (r_cnt == c_CNT_W'(GAP_CYC - 1))   w_state_nxt = S_ADVANCE;
      S_DELAY:   if (r_cnt == c_CNT_W'(DELAY_CYC - 1)) w_state_nxt = S_ADVANCE;
      S_ADVANCE: begin
        // The last table slot ends the run instead of wrapping to entry 0.
        if (r_addr == {ADDR_W{1'b1}}) begin
          w_state_nxt = S_DONE;
        end else begin
          w_addr_nxt  = r_addr + ADDR_W'(1);
          w_state_nxt = S_FETCH;
        end
      end
      S_DONE: begin
        w_send_nxt = 1'b0;
        if (bus.resend) begin
          w_addr_nxt  = '0;
          w_state_nxt = S_FETCH;
        end
      end
      default: w_state_nxt = S_STARTUP;
    endcase

    if (w_state_nxt != r_state) begin
      w_cnt_nxt = '0;
    end else if (r_state == S_STARTUP || r_state == S_GAP || r_state == S_DELAY) begin
      w_cnt_nxt = r_cnt + c_CNT_W'(1);
    end
  end

  assign bus.rom_addr = r_addr;
  assign bus.send     = r_send;
  assign bus.id       = CAM_ID;
  assign bus.regi     = r_regi;
  assign bus.value    = r_value;
  assign bus.done     = (r_state == S_DONE);
  assign bus.busy     = (r_state != S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_ov7670_config_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_ov7670_config_ctrl                                           |
// | Purpose  : Self-checking bench: table vectors, corner sequences, random.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_ov7670_config_ctrl;
  localparam int STARTUP = 20;
  localparam int GAP     = 8;
  localparam int DLY     = 50;
  localparam logic [15:0] END_M = 16'hFFFF;
  localparam logic [15:0] DLY_M = 16'hFFF0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst2 = 1'b1;
  always #5 clk = ~clk;

  ov7670_config_ctrl_if #(.ADDR_W(8)) bus ();
  ov7670_config_ctrl_if #(.ADDR_W(2)) bus2 ();

  ov7670_config_ctrl #(.CAM_ID(8'h42), .ADDR_W(8), .STARTUP_CYC(STARTUP),
                       .GAP_CYC(GAP), .DELAY_CYC(DLY))
    dut (.clk(clk), .rst(rst), .bus(bus));

  ov7670_config_ctrl #(.CAM_ID(8'h42), .ADDR_W(2), .STARTUP_CYC(STARTUP),
                       .GAP_CYC(GAP), .DELAY_CYC(DLY))
    dut2 (.clk(clk), .rst(rst2), .bus(bus2));

  logic [15:0] rom  [256];
  logic [15:0] rom2 [4];
  always @(posedge clk) bus.rom_data  <= rom[bus.rom_addr];
  always @(posedge clk) bus2.rom_data <= rom2[bus2.rom_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Sender model: logs each write and returns taken take_dly clocks after send rises.
  int          take_dly = 3;
  int          take_lim = 1000;
  int          rise_cnt = 0;
  logic        prev_send = 1'b0;
  logic [15:0] wr_q[$];
  int          rise_q[$];
  int          take_q[$];
  initial begin
    bus.taken = 1'b0;
    forever begin
      @(negedge clk);
      bus.taken = 1'b0;
      if (bus.send && !prev_send) begin
        wr_q.push_back({bus.regi, bus.value});
        rise_q.push_back(cyc);
        rise_cnt = 1;
      end else if (bus.send) begin
        rise_cnt++;
      end else begin
        rise_cnt = 0;
      end
      if (bus.send && rise_cnt == take_dly && wr_q.size() <= take_lim) begin
        bus.taken = 1'b1;
        take_q.push_back(cyc + 1);
      end
      prev_send = bus.send;
    end
  end

  int n2 = 0;
  initial begin
    bus2.taken = 1'b0;
    forever begin
      @(negedge clk);
      if (bus2.send && !bus2.taken) begin
        bus2.taken = 1'b1;
        n2++;
      end else begin
        bus2.taken = 1'b0;
      end
    end
  end

  int rel_cyc = 0;
  task automatic clear_log();
    wr_q.delete();
    rise_q.delete();
    take_q.delete();
  endtask

  task automatic load_rom(input logic [15:0] t[$]);
    for (int i = 0; i < 256; i++) rom[i] = END_M;
    for (int i = 0; i < t.size(); i++) rom[i] = t[i];
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_log();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rel_cyc = cyc;
  endtask

  task automatic wait_done(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_writes(input int n, input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (wr_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    logic [15:0] ent [6];
    int          nwr;
    logic [15:0] wr0;
    logic [15:0] wr1;
    int          gap01;
  } vec_t;
  vec_t vecs [4];

  logic [15:0] tbl[$];
  logic [15:0] exp_w[$];
  int          exp_d[$];
  bit          ok;
  int          nw, d, r0;
  logic [15:0] w;

  initial begin
    bus.resend  = 1'b0;
    bus2.resend = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = END_M;
    rom2[0] = 16'h0A01; rom2[1] = 16'h0B02; rom2[2] = 16'h0C03; rom2[3] = 16'h0D04;

    vecs[0].ent = '{16'h1280, 16'h1204, END_M, END_M, END_M, END_M};
    vecs[0].nwr = 2; vecs[0].wr0 = 16'h1280; vecs[0].wr1 = 16'h1204; vecs[0].gap01 = GAP + 3;
    vecs[1].ent = '{16'h1280, DLY_M, 16'h1100, END_M, END_M, END_M};
    vecs[1].nwr = 2; vecs[1].wr0 = 16'h1280; vecs[1].wr1 = 16'h1100; vecs[1].gap01 = 8 + 50 + 6;
    vecs[2].ent = '{16'h3A04, DLY_M, DLY_M, 16'h4000, END_M, END_M};
    vecs[2].nwr = 2; vecs[2].wr0 = 16'h3A04; vecs[2].wr1 = 16'h4000; vecs[2].gap01 = 8 + 3 + 2 * 53;
    vecs[3].ent = '{16'h0102, 16'h0304, 16'h0506, END_M, END_M, END_M};
    vecs[3].nwr = 3; vecs[3].wr0 = 16'h0102; vecs[3].wr1 = 16'h0304; vecs[3].gap01 = GAP + 3;

    // Reset state while rst is held.
    #1;
    chk("rst_send", 32'(bus.send), 32'd0);
    chk("rst_addr", 32'(bus.rom_addr), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd1);
    chk("rst_id", 32'(bus.id), 32'h42);
    chk("rst_regi", 32'(bus.regi), 32'd0);
    chk("rst_value", 32'(bus.value), 32'd0);

    // Table-driven programs.
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < 256; i++) rom[i] = END_M;
      for (int j = 0; j < 6; j++) rom[j] = vecs[v].ent[j];
      take_dly = 3;
      take_lim = 1000;
      do_reset();
      wait_done(2000, ok);
      chk($sformatf("v%0d_done", v), 32'(ok), 32'd1);
      chk($sformatf("v%0d_nwr", v), 32'(wr_q.size()), 32'(vecs[v].nwr));
      if (wr_q.size() >= 2 && take_q.size() >= 1) begin
        chk($sformatf("v%0d_first", v), 32'(rise_q[0] - rel_cyc), 32'(STARTUP + 2));
        chk($sformatf("v%0d_wr0", v), 32'(wr_q[0]), 32'(vecs[v].wr0));
        chk($sformatf("v%0d_wr1", v), 32'(wr_q[1]), 32'(vecs[v].wr1));
        chk($sformatf("v%0d_gap01", v), 32'(rise_q[1] - take_q[0]), 32'(vecs[v].gap01));
      end
      chk($sformatf("v%0d_busy", v), 32'(bus.busy), 32'd0);
      repeat (30) @(negedge clk);
      chk($sformatf("v%0d_quiet", v), 32'(wr_q.size()), 32'(vecs[v].nwr));
    end

    // Resend from DONE replays without the startup wait; resend mid-run is ignored.
    tbl = '{16'h1280, 16'h1204, END_M};
    load_rom(tbl);
    clear_log();
    @(negedge clk); bus.resend = 1'b1;
    @(negedge clk); bus.resend = 1'b0;
    r0 = cyc;
    chk("resend_addr", 32'(bus.rom_addr), 32'd0);
    chk("resend_busy", 32'(bus.busy), 32'd1);
    wait_writes(1, 200, ok);
    chk("resend_first_seen", 32'(ok), 32'd1);
    if (ok) chk("resend_first", 32'(rise_q[0] - r0), 32'd2);
    repeat (5) @(negedge clk);
    bus.resend = 1'b1;
    @(negedge clk); bus.resend = 1'b0;
    wait_done(2000, ok);
    chk("resend_done", 32'(ok), 32'd1);
    chk("resend_nwr", 32'(wr_q.size()), 32'd2);
    if (wr_q.size() >= 2 && take_q.size() >= 1) begin
      chk("resend_wr1", 32'(wr_q[1]), 32'h1204);
      chk("resend_gap", 32'(rise_q[1] - take_q[0]), 32'(GAP + 3));
    end

    // send held without taken; regi/value stable.
    tbl = '{16'h1280, END_M};
    load_rom(tbl);
    take_lim = 0;
    do_reset();
    wait_writes(1, 200, ok);
    chk("hold_seen", 32'(ok), 32'd1);
    if (ok) chk("hold_first", 32'(rise_q[0] - rel_cyc), 32'(STARTUP + 2));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_send", 32'(bus.send), 32'd1);
      chk("hold_data", 32'({bus.regi, bus.value}), 32'h1280);
    end

    // Async reset while the second write is pending.
    tbl = '{16'h1280, 16'h1204, END_M};
    load_rom(tbl);
    take_lim = 1;
    do_reset();
    wait_writes(2, 500, ok);
    chk("arst_seen", 32'(ok), 32'd1);
    repeat (2) @(negedge clk);
    chk("arst_pre_addr", 32'(bus.rom_addr), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_send", 32'(bus.send), 32'd0);
    chk("arst_addr", 32'(bus.rom_addr), 32'd0);
    chk("arst_done", 32'(bus.done), 32'd0);
    take_lim = 1000;
    @(negedge clk);
    clear_log();
    @(negedge clk);
    rst = 1'b0;
    rel_cyc = cyc;
    wait_done(2000, ok);
    chk("arst_redone", 32'(ok), 32'd1);
    chk("arst_nwr", 32'(wr_q.size()), 32'd2);
    if (wr_q.size() >= 1) chk("arst_first", 32'(rise_q[0] - rel_cyc), 32'(STARTUP + 2));

    // Randomised tables against a timing model built from the latency rules.
    for (int r = 0; r < 6; r++) begin
      tbl.delete(); exp_w.delete(); exp_d.delete();
      nw = $urandom_range(2, 5);
      for (int k = 0; k < nw; k++) begin
        d = 0;
        while (d < 2 && $urandom_range(0, 3) == 0) begin
          tbl.push_back(DLY_M);
          d++;
        end
        w = {8'($urandom_range(0, 254)), 8'($urandom_range(0, 255))};
        tbl.push_back(w);
        exp_w.push_back(w);
        exp_d.push_back(d);
      end
      tbl.push_back(END_M);
      load_rom(tbl);
      take_dly = $urandom_range(1, 5);
      do_reset();
      wait_done(5000, ok);
      chk($sformatf("rnd%0d_done", r), 32'(ok), 32'd1);
      chk($sformatf("rnd%0d_nwr", r), 32'(wr_q.size()), 32'(exp_w.size()));
      for (int k = 0; k < exp_w.size() && k < wr_q.size(); k++) begin
        chk($sformatf("rnd%0d_wr%0d", r, k), 32'(wr_q[k]), 32'(exp_w[k]));
        if (k == 0)
          chk($sformatf("rnd%0d_first", r), 32'(rise_q[0] - rel_cyc),
              32'(STARTUP + 2 + (DLY + 3) * exp_d[0]));
        else if (k <= take_q.size())
          chk($sformatf("rnd%0d_gap%0d", r, k), 32'(rise_q[k] - take_q[k-1]),
              32'(GAP + 3 + (DLY + 3) * exp_d[k]));
      end
    end

    // Narrow table without an end marker: stops at the last slot, no wrap.
    @(negedge clk); rst2 = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus2.done) begin
        ok = 1'b1;
        break;
      end
    end
    chk("a2_done", 32'(ok), 32'd1);
    chk("a2_nwr", 32'(n2), 32'd4);
    chk("a2_addr", 32'(bus2.rom_addr), 32'd3);
    repeat (30) @(negedge clk);
    chk("a2_quiet", 32'(n2), 32'd4);
    chk("a2_addr_hold", 32'(bus2.rom_addr), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
